// File: rtl/control_sequencer_if.sv
// Sequencer <-> instruction memory / ALU datapath bundle; master is the sequencer.
// Instruction fetch uses req/valid; datapath controls are single-cycle strobes.
interface control_sequencer_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
);
  logic                     instr_req;
  logic [DATA_WIDTH-1:0]    instr_addr;
  logic                     instr_valid;
  logic [DATA_WIDTH-1:0]    instr_data;
  logic [2:0]               ALUctrl;
  logic                     ALUsrc;
  logic [ADDRESS_WIDTH-1:0] rs1;
  logic [ADDRESS_WIDTH-1:0] rs2;
  logic [ADDRESS_WIDTH-1:0] rd;
  logic                     RegWrite;
  logic [DATA_WIDTH-1:0]    ImmOp;
  logic                     EQ;

  modport master (
    output instr_req, instr_addr, ALUctrl, ALUsrc, rs1, rs2, rd, RegWrite, ImmOp,
    input  instr_valid, instr_data, EQ
  );

  modport slave (
    input  instr_req, instr_addr, ALUctrl, ALUsrc, rs1, rs2, rd, RegWrite, ImmOp,
    output instr_valid, instr_data, EQ
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle RV32I subset controller (ADDI/ADD/SUB/BEQ/BNE): FETCH->DECODE->EXECUTE,
// 3 cycles per instruction plus one per memory wait cycle; stalls in FETCH until instr_valid.
module control_sequencer #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDRESS_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] RESET_PC      = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  control_sequencer_if.master   bus,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] instret,
  output logic                  halted
);

  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, TRAP} state_t;

  localparam logic [2:0]            ALU_ADD = 3'b000;
  localparam logic [2:0]            ALU_SUB = 3'b001;
  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);

  state_t                   state;
  logic [DATA_WIDTH-1:0]    ir;
  logic [2:0]               alu_ctrl_q;
  logic                     alu_src_q;
  logic [DATA_WIDTH-1:0]    imm_q;
  logic                     reg_write_q;
  logic [ADDRESS_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic [DATA_WIDTH-1:0]    br_off;
  logic                     br_eq, br_ne;

  logic [6:0]               opcode;
  logic [2:0]               funct3;
  logic [6:0]               funct7;
  logic                     dec_addi, dec_add, dec_sub, dec_beq, dec_bne, dec_legal;
  logic [DATA_WIDTH-1:0]    i_imm, b_imm;

  always_comb begin
    opcode    = ir[6:0];
    funct3    = ir[14:12];
    funct7    = ir[31:25];
    dec_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
    dec_add   = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    dec_sub   = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
    dec_beq   = (opcode == 7'b1100011) && (funct3 == 3'b000);
    dec_bne   = (opcode == 7'b1100011) && (funct3 == 3'b001);
    dec_legal = dec_addi | dec_add | dec_sub | dec_beq | dec_bne;
    i_imm     = {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};
    b_imm     = {{(DATA_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  end

  // Execute-stage controls are loaded on the DECODE->EXECUTE edge so they are
  // registered and valid for exactly the EXECUTE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ir          <= '0;
      instret     <= '0;
      halted      <= 1'b0;
      alu_ctrl_q  <= ALU_ADD;
      alu_src_q   <= 1'b0;
      imm_q       <= '0;
      reg_write_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      br_off      <= '0;
      br_eq       <= 1'b0;
      br_ne       <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.instr_valid) begin
            ir    <= bus.instr_data;
            state <= DECODE;
          end
        end
        DECODE: begin
          rs1_q  <= ir[19:15];
          rs2_q  <= ir[24:20];
          rd_q   <= ir[11:7];
          br_off <= b_imm;
          br_eq  <= dec_beq;
          br_ne  <= dec_bne;
          if (dec_legal) begin
            state       <= EXECUTE;
            alu_ctrl_q  <= (dec_sub | dec_beq | dec_bne) ? ALU_SUB : ALU_ADD;
            alu_src_q   <= dec_addi;
            imm_q       <= dec_addi ? i_imm : '0;
            reg_write_q <= (dec_addi | dec_add | dec_sub) && (ir[11:7] != 5'd0);
          end else begin
            state  <= TRAP;
            halted <= 1'b1;
          end
        end
        EXECUTE: begin
          alu_ctrl_q  <= ALU_ADD;
          alu_src_q   <= 1'b0;
          imm_q       <= '0;
          reg_write_q <= 1'b0;
          instret     <= instret + ONE;
          if ((br_eq & bus.EQ) | (br_ne & ~bus.EQ))
            pc <= pc + br_off;
          else
            pc <= pc + PC_STEP;
          state <= FETCH;
        end
        TRAP: begin
          halted <= 1'b1;
        end
        default: begin
          state  <= TRAP;
          halted <= 1'b1;
        end
      endcase
    end
  end

  assign bus.instr_req  = (state == FETCH);
  assign bus.instr_addr = pc;
  assign bus.ALUctrl    = alu_ctrl_q;
  assign bus.ALUsrc     = alu_src_q;
  assign bus.ImmOp      = imm_q;
  assign bus.RegWrite   = reg_write_q;
  assign bus.rs1        = rs1_q;
  assign bus.rs2        = rs2_q;
  assign bus.rd         = rd_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed plus randomized bench for control_sequencer against an instruction-level model.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc, instret;
  logic        halted;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_instret = 32'h0;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .pc     (pc),
    .instret(instret),
    .halted (halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        legal;
    logic [2:0]  ctrl;
    logic        src;
    logic [31:0] imm;
    logic        we;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] npc;
  } exp_t;

  // Architectural view of one instruction: what the datapath should be told and where pc goes.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] cur_pc, input logic eq);
    exp_t               e;
    string              mn;
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic               taken;
    mn = "bad";
    if (ins[6:0] == 7'h13 && ins[14:12] == 3'd0) mn = "addi";
    else if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 && ins[31:25] == 7'h00) mn = "add";
    else if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 && ins[31:25] == 7'h20) mn = "sub";
    else if (ins[6:0] == 7'h63 && ins[14:12] == 3'd0) mn = "beq";
    else if (ins[6:0] == 7'h63 && ins[14:12] == 3'd1) mn = "bne";
    i12     = ins[31:20];
    b13     = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    e.legal = (mn != "bad");
    e.rs1   = ins[19:15];
    e.rs2   = ins[24:20];
    e.rd    = ins[11:7];
    e.ctrl  = (mn == "add" || mn == "addi") ? 3'd0 : 3'd1;
    e.src   = (mn == "addi");
    e.imm   = (mn == "addi") ? 32'(int'(i12)) : 32'h0;
    e.we    = (mn == "addi" || mn == "add" || mn == "sub") && (e.rd != 5'd0);
    taken   = (mn == "beq" && eq) || (mn == "bne" && !eq);
    e.npc   = taken ? cur_pc + 32'(int'(b13)) : cur_pc + 32'd4;
    return e;
  endfunction

  function automatic logic [31:0] gen(input int kind);
    logic [4:0]  a, b, d;
    logic [11:0] i12;
    logic [12:0] bo;
    logic [31:0] w;
    a   = 5'($urandom);
    b   = 5'($urandom);
    d   = 5'($urandom);
    i12 = 12'($urandom);
    bo  = 13'($urandom);
    bo[0] = 1'b0;
    case (kind)
      0:       w = {i12, a, 3'b000, d, 7'b0010011};
      1:       w = {7'b0000000, b, a, 3'b000, d, 7'b0110011};
      2:       w = {7'b0100000, b, a, 3'b000, d, 7'b0110011};
      3:       w = {bo[12], bo[10:5], b, a, 3'b000, bo[4:1], bo[11], 7'b1100011};
      4:       w = {bo[12], bo[10:5], b, a, 3'b001, bo[4:1], bo[11], 7'b1100011};
      default: w = {7'b0000000, b, a, 3'b001, d, 7'b0110011};
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Asserts rst mid-cycle, checks the asynchronous effect, then releases just after an edge.
  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_regwrite", 32'(bus.RegWrite), 32'd0);
    chk("rst_aluctrl", 32'(bus.ALUctrl), 32'd0);
    chk("rst_alusrc", 32'(bus.ALUsrc), 32'd0);
    chk("rst_immop", bus.ImmOp, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    m_pc      = 32'h0;
    m_instret = 32'h0;
    chk("rst_req", 32'(bus.instr_req), 32'd1);
  endtask

  // Starts just after a rising edge with the DUT in FETCH; returns after EXECUTE,
  // or at the DECODE->TRAP negedge for an illegal word.
  task automatic run_instr(input logic [31:0] ins, input int waits, input logic eq_in);
    exp_t e;
    int   start;
    e     = model(ins, m_pc, eq_in);
    start = cyc;
    bus.instr_valid = 1'b0;
    for (int w = 0; w < waits; w++) begin
      bus.instr_data = $urandom;
      @(negedge clk);
      chk("wait_req", 32'(bus.instr_req), 32'd1);
      chk("wait_addr", bus.instr_addr, m_pc);
      @(posedge clk); #1;
    end
    bus.instr_valid = 1'b1;
    bus.instr_data  = ins;
    @(negedge clk);
    chk("fetch_req", 32'(bus.instr_req), 32'd1);
    chk("fetch_addr", bus.instr_addr, m_pc);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.instr_data  = $urandom;
    @(negedge clk);
    chk("dec_req", 32'(bus.instr_req), 32'd0);
    chk("dec_regwrite", 32'(bus.RegWrite), 32'd0);
    @(posedge clk); #1;
    if (!e.legal) begin
      @(negedge clk);
      chk("trap_halted", 32'(halted), 32'd1);
      chk("trap_req", 32'(bus.instr_req), 32'd0);
      chk("trap_pc", pc, m_pc);
      return;
    end
    bus.EQ = eq_in;
    @(negedge clk);
    chk("ex_aluctrl", 32'(bus.ALUctrl), 32'(e.ctrl));
    chk("ex_alusrc", 32'(bus.ALUsrc), 32'(e.src));
    chk("ex_immop", bus.ImmOp, e.imm);
    chk("ex_regwrite", 32'(bus.RegWrite), 32'(e.we));
    chk("ex_rs1", 32'(bus.rs1), 32'(e.rs1));
    chk("ex_rs2", 32'(bus.rs2), 32'(e.rs2));
    chk("ex_rd", 32'(bus.rd), 32'(e.rd));
    chk("ex_req", 32'(bus.instr_req), 32'd0);
    @(posedge clk); #1;
    bus.EQ    = 1'b0;
    m_pc      = e.npc;
    m_instret = m_instret + 32'd1;
    chk("post_pc", pc, m_pc);
    chk("post_instret", instret, m_instret);
    chk("post_regwrite", 32'(bus.RegWrite), 32'd0);
    chk("post_req", 32'(bus.instr_req), 32'd1);
    chk("latency", 32'(cyc - start), 32'(waits + 3));
  endtask

  task automatic trap_hold();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_halted", 32'(halted), 32'd1);
      chk("hold_req", 32'(bus.instr_req), 32'd0);
      chk("hold_pc", pc, m_pc);
    end
  endtask

  initial begin
    int k;
    bus.instr_valid = 1'b0;
    bus.instr_data  = 32'h0;
    bus.EQ          = 1'b0;

    do_reset();
    run_instr(32'h00500513, 0, 1'b0);
    chk("addi_pc", pc, 32'd4);
    chk("addi_instret", instret, 32'd1);

    do_reset();
    run_instr(32'h00A505B3, 0, 1'b0);
    run_instr(32'h40A58633, 0, 1'b0);
    chk("addsub_pc", pc, 32'd8);
    chk("addsub_instret", instret, 32'd2);
    run_instr(32'hFE051CE3, 0, 1'b0);
    chk("bne_taken_pc", pc, 32'd0);
    run_instr(32'h00A505B3, 0, 1'b0);
    run_instr(32'h40A58633, 0, 1'b0);
    run_instr(32'hFE051CE3, 0, 1'b1);
    chk("bne_fall_pc", pc, 32'd12);

    do_reset();
    run_instr(32'h00500513, 4, 1'b0);
    run_instr(32'h00100013, 1, 1'b0);
    chk("x0_instret", instret, 32'd2);

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 4);
      if ($urandom_range(0, 15) == 0) k = 5;
      run_instr(gen(k), $urandom_range(0, 3), 1'($urandom));
      if (k == 5) begin
        trap_hold();
        do_reset();
      end
    end

    run_instr(32'h00000000, 0, 1'b0);
    trap_hold();
    do_reset();
    run_instr(32'h00500513, 0, 1'b0);
    chk("after_trap_pc", pc, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
